// File: rtl/vmx_hold_pkg.sv
// Shared definitions for the CPU hold / DMA arbiter: state encoding, stall counter width
// and default timing limits.
package vmx_hold_pkg;

    localparam int unsigned STALL_W     = 16;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned DMA_MAX_DEF = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_MWAIT = 2'd1;
    localparam state_t ST_DMA   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a simultaneous increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hold_arbiter.sv
// CPU hold generator: passes the divider hold through, stalls the CPU on external memory
// waits (with timeout) and hands the bus to a DMA master for bounded bursts.
module hold_arbiter
    import vmx_hold_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DMA_MAX = DMA_MAX_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               div_hold,
    input  logic               mem_req,
    input  logic               mem_ack,
    input  logic               dma_req,
    input  logic               stat_clr,
    output logic               hold,
    output logic               dma_grant,
    output logic               timeout,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DMA_W  = $clog2(DMA_MAX + 1);

    state_t            state;
    state_t            state_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_n;
    logic [DMA_W-1:0]  dma_cnt;
    logic [DMA_W-1:0]  dma_cnt_n;
    logic              hold_n;
    logic              grant_n;
    logic              to_hit;

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            dma_cnt   <= '0;
            hold      <= 1'b1;
            dma_grant <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            dma_cnt   <= dma_cnt_n;
            hold      <= hold_n;
            dma_grant <= grant_n;
        end
    end

    // Next state; leaving DMA always lands in RUN for a cycle, which gives the mandatory gap
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        dma_cnt_n  = dma_cnt;
        hold_n     = div_hold;
        grant_n    = 1'b0;
        to_hit     = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_req) begin
                    if (!mem_ack) begin
                        state_n    = ST_MWAIT;
                        hold_n     = 1'b0;
                        wait_cnt_n = '0;
                    end
                end else if (dma_req) begin
                    state_n   = ST_DMA;
                    grant_n   = 1'b1;
                    hold_n    = 1'b0;
                    dma_cnt_n = '0;
                end
            end
            ST_MWAIT: begin
                hold_n     = 1'b0;
                wait_cnt_n = wait_cnt + WAIT_W'(1);
                if (mem_ack) begin
                    state_n = ST_RUN;
                    hold_n  = div_hold;
                end else if (wait_cnt_n == WAIT_W'(TIMEOUT)) begin
                    state_n = ST_RUN;
                    hold_n  = div_hold;
                    to_hit  = 1'b1;
                end
            end
            ST_DMA: begin
                hold_n    = 1'b0;
                grant_n   = 1'b1;
                dma_cnt_n = dma_cnt + DMA_W'(1);
                if (!dma_req || (dma_cnt_n == DMA_W'(DMA_MAX))) begin
                    state_n = ST_RUN;
                    grant_n = 1'b0;
                    hold_n  = div_hold;
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // Sticky timeout flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (stat_clr) begin
            timeout <= 1'b0;
        end else if (to_hit) begin
            timeout <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(STALL_W)
    ) u_stall_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (stat_clr),
        .inc    (~hold),
        .count  (stall_cnt)
    );

endmodule

// File: tb/tb_hold_arbiter.sv
// Directed bench for hold_arbiter with TIMEOUT=4 and DMA_MAX=64.
module tb_hold_arbiter;

    logic        clock;
    logic        reset_n;
    logic        div_hold;
    logic        mem_req;
    logic        mem_ack;
    logic        dma_req;
    logic        stat_clr;
    logic        hold;
    logic        dma_grant;
    logic        timeout;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    hold_arbiter #(
        .TIMEOUT(4),
        .DMA_MAX(64)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .div_hold (div_hold),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .dma_req  (dma_req),
        .stat_clr (stat_clr),
        .hold     (hold),
        .dma_grant(dma_grant),
        .timeout  (timeout),
        .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_stats();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        div_hold = 1'b1;
        mem_req  = 1'b0;
        mem_ack  = 1'b0;
        dma_req  = 1'b0;
        stat_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (hold !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b expected 1", hold); end
        total++;
        if (dma_grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b expected 0", dma_grant); end
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        total++;
        if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall: got %h expected 0000", stall_cnt); end
        reset_n = 1'b1;
    endtask

    task automatic test_div_pattern();
        logic pat [0:3];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            div_hold = pat[i];
            tick();
            total++;
            if (hold !== pat[i]) begin bad++; $display("FAIL div_pattern[%0d]: got %b expected %b", i, hold, pat[i]); end
        end
        total++;
        if (stall_cnt !== 16'd1) begin bad++; $display("FAIL div_pattern_stall: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_zero_wait();
        div_hold = 1'b0;
        mem_req  = 1'b1;
        mem_ack  = 1'b1;
        tick();
        total++;
        if (hold !== 1'b0 || dma_grant !== 1'b0) begin bad++; $display("FAIL zero_wait_hold: got hold=%b grant=%b expected 0/0", hold, dma_grant); end
        mem_req  = 1'b0;
        mem_ack  = 1'b0;
        div_hold = 1'b1;
        tick();
        total++;
        if (hold !== 1'b1) begin bad++; $display("FAIL zero_wait_run: got %b expected 1", hold); end
    endtask

    task automatic test_mem_ack_boundary();
        clr_stats();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (hold !== 1'b0) begin bad++; $display("FAIL mwait_hold[%0d]: got %b expected 0", i, hold); end
        end
        mem_ack = 1'b1;
        mem_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        total++;
        if (hold !== 1'b1) begin bad++; $display("FAIL mwait_ack_hold: got %b expected 1", hold); end
        total++;
        if (timeout !== 1'b0) begin bad++; $display("FAIL mwait_ack_timeout: got %b expected 0", timeout); end
        total++;
        if (stall_cnt !== 16'd4) begin bad++; $display("FAIL mwait_stall: got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_early_ack();
        mem_req = 1'b1;
        tick();
        mem_ack = 1'b1;
        mem_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        total++;
        if (hold !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL early_ack: got hold=%b timeout=%b expected 1/0", hold, timeout); end
    endtask

    task automatic test_timeout();
        clr_stats();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (hold !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL to_wait[%0d]: got hold=%b timeout=%b expected 0/0", i, hold, timeout); end
        end
        mem_req = 1'b0;
        tick();
        total++;
        if (hold !== 1'b1 || timeout !== 1'b1) begin bad++; $display("FAIL to_exit: got hold=%b timeout=%b expected 1/1", hold, timeout); end
        tick();
        total++;
        if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b expected 1", timeout); end
        clr_stats();
        total++;
        if (timeout !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL to_clear: got timeout=%b stall=%0d expected 0/0", timeout, stall_cnt); end
    endtask

    task automatic test_dma_max();
        int first_ones;
        int all_ones;
        first_ones = 0;
        all_ones   = 0;
        clr_stats();
        dma_req = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (dma_grant === 1'b1) all_ones++;
            if (k <= 64 && dma_grant === 1'b1 && hold === 1'b0) first_ones++;
            if (k == 65) begin
                total++;
                if (dma_grant !== 1'b0 || hold !== 1'b1) begin bad++; $display("FAIL dma_gap: got grant=%b hold=%b expected 0/1", dma_grant, hold); end
            end
            if (k == 66) begin
                total++;
                if (dma_grant !== 1'b1) begin bad++; $display("FAIL dma_regrant: got %b expected 1", dma_grant); end
            end
        end
        total++;
        if (first_ones != 64) begin bad++; $display("FAIL dma_first_burst: got %0d expected 64", first_ones); end
        total++;
        if (all_ones != 99) begin bad++; $display("FAIL dma_total_grants: got %0d expected 99", all_ones); end
        dma_req = 1'b0;
        tick();
        total++;
        if (dma_grant !== 1'b0 || hold !== 1'b1) begin bad++; $display("FAIL dma_release: got grant=%b hold=%b expected 0/1", dma_grant, hold); end
        total++;
        if (stall_cnt !== 16'd99) begin bad++; $display("FAIL dma_stall: got %0d expected 99", stall_cnt); end
    endtask

    task automatic test_priority();
        mem_req = 1'b1;
        dma_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dma_grant !== 1'b0 || hold !== 1'b0) begin bad++; $display("FAIL prio_wait[%0d]: got grant=%b hold=%b expected 0/0", i, dma_grant, hold); end
        end
        mem_ack = 1'b1;
        mem_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        total++;
        if (dma_grant !== 1'b0 || hold !== 1'b1) begin bad++; $display("FAIL prio_ack: got grant=%b hold=%b expected 0/1", dma_grant, hold); end
        tick();
        total++;
        if (dma_grant !== 1'b1) begin bad++; $display("FAIL prio_dma_after: got %b expected 1", dma_grant); end
        dma_req = 1'b0;
        tick();
        total++;
        if (dma_grant !== 1'b0) begin bad++; $display("FAIL prio_dma_drop: got %b expected 0", dma_grant); end
    endtask

    task automatic test_reset_mid_dma();
        dma_req = 1'b1;
        repeat (2) tick();
        total++;
        if (dma_grant !== 1'b1) begin bad++; $display("FAIL rst_dma_pre: got %b expected 1", dma_grant); end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (dma_grant !== 1'b0 || hold !== 1'b1) begin bad++; $display("FAIL rst_dma_async: got grant=%b hold=%b expected 0/1", dma_grant, hold); end
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_dma_stall: got %0d expected 0", stall_cnt); end
        dma_req  = 1'b0;
        div_hold = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        total++;
        if (dma_grant !== 1'b0 || hold !== 1'b0) begin bad++; $display("FAIL rst_first_edge: got grant=%b hold=%b expected 0/0", dma_grant, hold); end
        div_hold = 1'b1;
        tick();
        total++;
        if (hold !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL rst_resume: got hold=%b timeout=%b expected 1/0", hold, timeout); end
    endtask

    task automatic test_stall_sat();
        div_hold = 1'b0;
        clr_stats();
        total++;
        if (stall_cnt !== 16'd0 || hold !== 1'b0) begin bad++; $display("FAIL sat_start: got stall=%h hold=%b expected 0000/0", stall_cnt, hold); end
        repeat (65534) tick();
        total++;
        if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h expected fffe", stall_cnt); end
        tick();
        total++;
        if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %h expected ffff", stall_cnt); end
        repeat (3) tick();
        total++;
        if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h expected ffff", stall_cnt); end
        clr_stats();
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL sat_clr_prio: got %h expected 0000", stall_cnt); end
        tick();
        total++;
        if (stall_cnt !== 16'd1) begin bad++; $display("FAIL sat_restart: got %h expected 0001", stall_cnt); end
        div_hold = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_div_pattern();
        test_zero_wait();
        test_mem_ack_boundary();
        test_early_ack();
        test_timeout();
        test_dma_max();
        test_priority();
        test_reset_mid_dma();
        test_stall_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hold_arbiter.md
HOLD_ARBITER -- requirements
Module: hold_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in MWAIT before forced release.
REQ-002 Parameter DMA_MAX, default 64: maximum consecutive cycles of a single DMA grant.
REQ-003 clock  input  1  the single clock for all logic; every register is updated on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 div_hold  input  1  hold from the upstream frequency divider; 1 = run slot, 0 = throttled.
REQ-006 mem_req  input  1  level, 1 = the CPU has started a memory cycle needing external acknowledge.
REQ-007 mem_ack  input  1  single-cycle pulse from memory, 1 = the current cycle is complete.
REQ-008 dma_req  input  1  level, 1 = a DMA master requests the bus.
REQ-009 stat_clr  input  1  synchronous pulse that clears stall_cnt and timeout.
REQ-010 hold  output  1  registered CPU hold; 1 = CPU runs, 0 = CPU is held.
REQ-011 dma_grant  output  1  registered; 1 = the DMA master owns the bus.
REQ-012 timeout  output  1  sticky flag, 1 = an MWAIT timeout has occurred.
REQ-013 stall_cnt  output  16  saturating count of cycles with hold=0.

Function
REQ-014 The block SHALL implement a three-state FSM: RUN, MWAIT and DMA.
REQ-015 In RUN with mem_req=1 and mem_ack=0, the next state SHALL be MWAIT and hold SHALL be 0 on the next cycle.
REQ-016 In RUN with mem_req=1 and mem_ack=1 in the same cycle, the state SHALL stay RUN and hold SHALL equal div_hold on the next cycle (zero-wait access).
REQ-017 In RUN with mem_req=0 and dma_req=1, the next state SHALL be DMA, with dma_grant=1 and hold=0 on the next cycle.
REQ-018 If mem_req and dma_req are both 1 in RUN, mem_req SHALL win.
REQ-019 In RUN with no request, hold SHALL be div_hold registered: one cycle of latency.
REQ-020 MWAIT SHALL hold hold=0 and increment a wait counter of width ceil(log2(TIMEOUT+1)).
REQ-021 MWAIT SHALL leave for RUN on mem_ack=1; hold SHALL become div_hold on the next cycle.
REQ-022 MWAIT SHALL leave for RUN when the wait counter equals TIMEOUT; timeout SHALL be set to 1 on that exit.
REQ-023 If mem_ack=1 arrives in the same cycle the counter reaches TIMEOUT, the exit SHALL count as an acknowledge and timeout SHALL NOT be set.
REQ-024 The wait counter SHALL be cleared on every entry to MWAIT.
REQ-025 dma_req SHALL be ignored while in MWAIT.
REQ-026 DMA SHALL hold dma_grant=1 and hold=0, and SHALL count grant cycles.
REQ-027 DMA SHALL return to RUN when dma_req=0 or after DMA_MAX grant cycles.
REQ-028 After any return from DMA, the FSM SHALL spend at least one cycle in RUN with hold=div_hold before DMA may be re-entered; a mem_req during that cycle is still accepted.
REQ-029 dma_grant SHALL fall in the same cycle that the state leaves DMA.
REQ-030 stall_cnt SHALL increment every cycle that hold=0 and SHALL saturate at 16'hFFFF.
REQ-031 stat_clr SHALL have priority over a simultaneous increment (the result is 0) and SHALL clear timeout.

Reset
REQ-032 While reset_n=0, the block SHALL force: state=RUN, hold=1, dma_grant=0, timeout=0, stall_cnt=0, and all internal counters 0.
REQ-033 Reset asserted mid-MWAIT or mid-DMA SHALL abort the transaction immediately, with no further grant cycle after release.
REQ-034 The first edge after reset release SHALL evaluate the RUN transitions normally.

Structure
REQ-035 The state enum, the stall_cnt width and the default TIMEOUT/DMA_MAX values SHALL live in the shared package vmx_hold_pkg.
REQ-036 The saturating counter with clear SHALL be the single sub-module sat_counter, parameterised by width, and used for stall_cnt.

Verification
REQ-037 Bench SHALL cover: div_hold pattern 1,0,1,1 with no requests -> hold 1,0,1,1 delayed by one cycle, stall_cnt=1.
REQ-038 Bench SHALL cover: mem_req at cycle 5, mem_ack at cycle 9 -> hold=0 for cycles 6-9, hold=div_hold from cycle 10, timeout=0.
REQ-039 Bench SHALL cover: TIMEOUT=4 and mem_req with no ack -> exit after 4 wait cycles, timeout=1, cleared by stat_clr.
REQ-040 Bench SHALL cover: dma_req held for 100 cycles with DMA_MAX=64 -> dma_grant for 64 cycles, one RUN cycle, then re-grant.
REQ-041 Bench SHALL cover: mem_req and dma_req rising together -> MWAIT entered and dma_grant stays 0 until the ack.
REQ-042 Bench SHALL cover: reset_n pulled low during DMA -> dma_grant=0 and hold=1 immediately, stall_cnt=0; and stall_cnt at 16'hFFFF with hold=0 -> remains 16'hFFFF.
